// File: rtl/serial_debug_tx.sv
// serial_debug_tx
//   Byte-serial (UART-style, LSB first) transmitter for streaming debug and
//   status bytes from the CPU debug port to the board header pin. The frame
//   format matches the board's serial debug receiver.
//
//   Frame: start(0), DATA_BITS payload bits LSB first, optional parity bit,
//   STOP_BITS stop bits(1). Each bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk        system clock, rising-edge
//   rst        synchronous active-high reset
//   tx_data    payload, sampled only on the accept edge
//   tx_valid   producer has a byte available
//   tx_ready   transmitter accepts a byte this cycle (high only in IDLE)
//   txd        serial line, idle high, driven straight from a flop
//   busy       high from the cycle after accept until the last stop bit ends
//   frame_done one-cycle pulse in the final cycle of the last stop bit
//
// state  | meaning
// IDLE   | line high, waiting for tx_valid
// START  | start bit (txd=0)
// DATA   | payload bits, LSB first, shifting right after each bit
// PARITY | parity bit (only when PARITY != 0)
// STOP   | stop bit(s), txd=1; frame_done in the last cycle

module serial_debug_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 frame_done
);

  generate
    if (PARITY != 0 && PARITY != 1 && PARITY != 2) begin : g_bad_parity
      $error("serial_debug_tx: PARITY must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("serial_debug_tx: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("serial_debug_tx: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("serial_debug_tx: CLKS_PER_BIT must be 2..65535");
    end
  endgenerate

  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          USE_PAR   = (PARITY != 0);
  localparam logic          ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q,  state_d;
  logic [BW-1:0]          baud_q,   baud_d;
  logic [2:0]             bit_q,    bit_d;
  logic [DATA_BITS-1:0]   shift_q,  shift_d;
  logic                   parity_q, parity_d;
  logic                   txd_q,    txd_d;

  logic baud_tc;

  assign baud_tc = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txd_q    <= txd_d;
    end
  end

  // txd_d is the line level for the state being entered, so txd changes on
  // the same edge as the state and never passes through combinational logic.
  // bit_q doubles as the stop-bit counter once DATA is finished.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    txd_d    = txd_q;

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_PAR;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = S_START;
          txd_d    = 1'b0;
        end
      end

      S_START: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_DATA: begin
        if (baud_tc) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (USE_PAR) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_PARITY: begin
        if (baud_tc) begin
          baud_d  = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign txd        = txd_q;
  assign tx_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && baud_tc && (bit_q == STOP_LAST);

endmodule
